ds_linefill_rx: RTL and testbench
=================================

Name: ds_linefill_rx

Overview:
Receive side of the downstream data bus: it is the counterpart of the evict path, which serializes lines onto BUS_WIDTH beats.
- Accepts linefill data beats from downstream, each with a last flag.
- Assembles the beats into DATA_WIDTH segments and writes the segments into the LFDB in req_num order (DS_N segments per line).
- Signals linefill completion to the MSHR/ROB.
- Sits between the downstream response port and the LFDB.

Parameters:
BUS_WIDTH, 128, downstream beat width
DATA_WIDTH, 1024, segment width written to LFDB (multiple of BUS_WIDTH)
DS_N, 4, segments per cache line
DB_IDX_W, DB_ENTRY_IDX_WIDTH (5), LFDB entry index width
ROB_IDX_W, MSHR_ENTRY_IDX_WIDTH (6), ROB entry index width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ds_rxdat_vld  in  1  beat valid
ds_rxdat_rdy  out  1  beat ready
ds_rxdat_data  in  BUS_WIDTH  beat data
ds_rxdat_last  in  1  final beat of line
ds_rxdat_db_entry_id  in  DB_IDX_W  target LFDB entry
ds_rxdat_rob_entry_id  in  ROB_IDX_W  owning ROB entry
lfdb_wr_vld  out  1  segment write valid
lfdb_wr_rdy  in  1  segment write ready
lfdb_wr_data  out  DATA_WIDTH  assembled segment
lfdb_wr_db_entry_id  out  DB_IDX_W  LFDB entry
lfdb_wr_req_num  out  $clog2(DS_N)  segment index
lfdb_wr_last  out  1  final segment of line
lf_done_vld  out  1  one-cycle line-complete pulse
lf_done_rob_entry_id  out  ROB_IDX_W  completed ROB entry

Behaviour:
- Constants: SEG_BEATS = DATA_WIDTH/BUS_WIDTH (8); LINE_BEATS = SEG_BEATS*DS_N (32).
- Handshakes: valid/ready; transfer on vld&&rdy. Once a valid is asserted, it and its payload stay stable until accepted.
- Storage: two segment buffers (ping-pong), each in state EMPTY → FILLING → FULL. Fill pointer and drain pointer toggle independently.
- Beat counter beat_cnt (0..SEG_BEATS-1) and segment counter seg_cnt (0..DS_N-1).
  - An accepted beat is written to data[beat_cnt*BUS_WIDTH +: BUS_WIDTH] of the fill buffer.
  - On beat_cnt==SEG_BEATS-1 the buffer becomes FULL, tagged with seg_cnt and last=(seg_cnt==DS_N-1). beat_cnt wraps to 0 and seg_cnt increments, wrapping after DS_N-1.
- db_entry_id and rob_entry_id are captured on the first beat of each line (beat_cnt==0 and seg_cnt==0) and held for all DS_N segments. Ids on later beats are ignored.
- ds_rxdat_rdy = fill buffer not FULL, registered-state only (no combinational path from lfdb_wr_rdy).
- lfdb_wr_vld = drain buffer FULL. Its payload comes directly from the drain buffer. On handshake the buffer goes EMPTY and the drain pointer toggles.
- Latency: lfdb_wr_vld rises the cycle after the segment's final beat is accepted.
- Throughput: 1 beat/cycle sustained while lfdb_wr_rdy=1. Back-to-back lines have no bubble.
- Simultaneous fill-complete and drain in one cycle is legal; both pointers update.
- lf_done_vld pulses one cycle after the handshake of the segment with last=1. It carries that line's rob_entry_id.
- ds_rxdat_last on the final beat (beat 31) is the normal case; the last flag otherwise has no effect on counters unless LFRX_ERR_CHK_EN is defined.
- Reset (asserted at any time, including mid-line): both buffers EMPTY, all counters 0. Reset values of outputs:
  - ds_rxdat_rdy=1
  - lfdb_wr_vld=0, lfdb_wr_data=0, lfdb_wr_db_entry_id=0, lfdb_wr_req_num=0, lfdb_wr_last=0
  - lf_done_vld=0, lf_done_rob_entry_id=0
  - err_early_last=0
- A partially received line is discarded on reset. The next beat starts at segment 0.

Optional Feature:
Macro LFRX_ERR_CHK_EN.
- Defined, output err_early_last (1 bit) is added. It is sticky and cleared only by reset.
- Defined, ds_rxdat_last on any beat other than the line's final beat sets err_early_last.
  - The current buffer is closed FULL: unreceived beats read as zero, last=1.
  - Counters reset to 0, and lf_done still fires on its drain.
- Defined, ds_rxdat_last=0 on the final beat also sets err_early_last; the line completes normally.
- Undefined: port absent; last ignored; counters alone delimit lines.

Decomposition:
- Package: add the constants LFRX_SEG_BEATS and LFRX_LINE_BEATS.
- Package: add typedef lfrx_seg_t {data[DATA_WIDTH], db_entry_id, rob_entry_id, req_num, last} for the segment buffer and LFDB write payload.
- Reuse the existing DB/MSHR index widths.
- Sub-module: lfrx_seg_buf, a single segment buffer with a state machine and beat insert. Instantiate it twice.

Test Plan:
1. One line: 32 beats, beat i data = i, db 3, rob 5, lfdb_wr_rdy=1 → 4 writes with req_num 0..3. Segment k word j = 8k+j. last only on req_num 3. lf_done_vld one cycle later with rob 5.
2. Backpressure: lfdb_wr_rdy=0 while 32 beats are offered → ds_rxdat_rdy drops after beat 16. Raise rdy → all 4 segments arrive in order, no data loss or duplication.
3. Back-to-back lines with db 3/rob 5 then db 7/rob 9, rdy=1 → 64 beats accepted in 64 cycles. 8 writes with correct ids; two lf_done pulses, rob 5 then rob 9.
4. With LFRX_ERR_CHK_EN, last on beat 10 → err_early_last=1 sticky. Segment 1 is written with words 0–2 valid, 3–7 zero, last=1. lf_done fires. Next line starts at req_num 0.
5. rst_n asserted after beat 12 → all outputs at reset values immediately. A fresh 32-beat line after release produces req_num 0..3 correctly.

Source files
------------

// File: rtl/ds_linefill_rx_pkg.sv
// ---------------------------------------------------------------------------
// ds_linefill_rx_pkg
// Shared constants and types for the downstream linefill receive path.
//   - Bus/segment/line geometry (beats per segment, beats per line).
//   - LFDB / MSHR index widths reused for entry ids.
//   - Segment buffer state encoding and the segment payload record, which is
//     also the LFDB write payload.
// ---------------------------------------------------------------------------
package ds_linefill_rx_pkg;

   localparam int BUS_WIDTH            = 128;
   localparam int DATA_WIDTH           = 1024;
   localparam int DS_N                 = 4;
   localparam int DB_ENTRY_IDX_WIDTH   = 5;
   localparam int MSHR_ENTRY_IDX_WIDTH = 6;

   localparam int DB_IDX_W  = DB_ENTRY_IDX_WIDTH;
   localparam int ROB_IDX_W = MSHR_ENTRY_IDX_WIDTH;
   localparam int REQ_NUM_W = $clog2(DS_N);

   localparam int LFRX_SEG_BEATS  = DATA_WIDTH / BUS_WIDTH;
   localparam int LFRX_LINE_BEATS = LFRX_SEG_BEATS * DS_N;
   localparam int BEAT_IDX_W      = $clog2(LFRX_SEG_BEATS);

   typedef enum logic [1:0] {
      SEG_EMPTY   = 2'd0,
      SEG_FILLING = 2'd1,
      SEG_FULL    = 2'd2
   } lfrx_seg_state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [DB_IDX_W-1:0]   db_entry_id;
      logic [ROB_IDX_W-1:0]  rob_entry_id;
      logic [REQ_NUM_W-1:0]  req_num;
      logic                  last;
   } lfrx_seg_t;

endpackage

// File: rtl/ds_linefill_rx_seg_buf.sv
// ---------------------------------------------------------------------------
// lfrx_seg_buf
// One segment buffer of the ping-pong pair: EMPTY -> FILLING -> FULL -> EMPTY.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   beat_en           insert beat_data at beat slot beat_idx
//   close             this beat completes the segment; latch the tag fields
//   tag_*             db/rob ids, req_num and last flag for the closed segment
//   drain_ack         LFDB accepted the segment; buffer returns to EMPTY
//   full              buffer holds a complete segment
//   seg               buffered segment (data + tag)
// ---------------------------------------------------------------------------
module lfrx_seg_buf
   import ds_linefill_rx_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  beat_en,
   input  logic [BEAT_IDX_W-1:0] beat_idx,
   input  logic [BUS_WIDTH-1:0]  beat_data,
   input  logic                  close,
   input  logic [DB_IDX_W-1:0]   tag_db_entry_id,
   input  logic [ROB_IDX_W-1:0]  tag_rob_entry_id,
   input  logic [REQ_NUM_W-1:0]  tag_req_num,
   input  logic                  tag_last,
   input  logic                  drain_ack,
   output logic                  full,
   output lfrx_seg_t             seg
);

   lfrx_seg_state_e state_q, state_d;
   lfrx_seg_t       seg_q, seg_d;

   always_comb begin
      // NOTE: defaults first so every path assigns every bit and no latch is inferred.
      state_d = state_q;
      seg_d   = seg_q;
      if (drain_ack && state_q == SEG_FULL) begin
         state_d = SEG_EMPTY;
      end
      if (beat_en && state_q != SEG_FULL) begin
         // A fresh segment starts zeroed so slots never written (early close) read as zero.
         if (state_q == SEG_EMPTY) begin
            seg_d.data = '0;
         end
         seg_d.data[int'(beat_idx)*BUS_WIDTH +: BUS_WIDTH] = beat_data;
         if (close) begin
            state_d            = SEG_FULL;
            seg_d.db_entry_id  = tag_db_entry_id;
            seg_d.rob_entry_id = tag_rob_entry_id;
            seg_d.req_num      = tag_req_num;
            seg_d.last         = tag_last;
         end else begin
            state_d = SEG_FILLING;
         end
      end
   end

   // NOTE: the wide data register is reset as well, because lfdb_wr_data must read zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEG_EMPTY;
         seg_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only; next-state math stays in always_comb.
         state_q <= state_d;
         seg_q   <= seg_d;
      end
   end

   assign full = (state_q == SEG_FULL);
   assign seg  = seg_q;

endmodule

// File: rtl/ds_linefill_rx.sv
// ---------------------------------------------------------------------------
// ds_linefill_rx
// Downstream linefill receiver: packs BUS_WIDTH beats into DATA_WIDTH segments
// through a ping-pong pair of segment buffers, writes them to the LFDB in
// req_num order and pulses lf_done when the last segment of a line is written.
// Ports:
//   ds_rxdat_*    beat input (valid/ready), data, last flag, LFDB/ROB ids
//   lfdb_wr_*     segment write output (valid/ready), data, id, req_num, last
//   lf_done_*     one-cycle line-complete pulse with the line's ROB id
//   err_early_last  (only with LFRX_ERR_CHK_EN) sticky last-flag protocol error
// Build option: define LFRX_ERR_CHK_EN to make ds_rxdat_last delimit lines
// and flag misplaced last flags; otherwise the counters alone delimit lines.
// ---------------------------------------------------------------------------
module ds_linefill_rx
   import ds_linefill_rx_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ds_rxdat_vld,
   output logic                  ds_rxdat_rdy,
   input  logic [BUS_WIDTH-1:0]  ds_rxdat_data,
   input  logic                  ds_rxdat_last,
   input  logic [DB_IDX_W-1:0]   ds_rxdat_db_entry_id,
   input  logic [ROB_IDX_W-1:0]  ds_rxdat_rob_entry_id,
   output logic                  lfdb_wr_vld,
   input  logic                  lfdb_wr_rdy,
   output logic [DATA_WIDTH-1:0] lfdb_wr_data,
   output logic [DB_IDX_W-1:0]   lfdb_wr_db_entry_id,
   output logic [REQ_NUM_W-1:0]  lfdb_wr_req_num,
   output logic                  lfdb_wr_last,
`ifdef LFRX_ERR_CHK_EN
   output logic                  err_early_last,
`endif
   output logic                  lf_done_vld,
   output logic [ROB_IDX_W-1:0]  lf_done_rob_entry_id
);

   logic                  fill_ptr_q, fill_ptr_d;
   logic                  drain_ptr_q, drain_ptr_d;
   logic [BEAT_IDX_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [REQ_NUM_W-1:0]  seg_cnt_q, seg_cnt_d;
   logic [DB_IDX_W-1:0]   line_db_q, line_db_d;
   logic [ROB_IDX_W-1:0]  line_rob_q, line_rob_d;
   logic                  lf_done_vld_q, lf_done_vld_d;
   logic [ROB_IDX_W-1:0]  lf_done_rob_q, lf_done_rob_d;

   logic [1:0]            buf_full;
   lfrx_seg_t             buf_seg [2];
   lfrx_seg_t             drain_seg;

   logic                  first_beat, seg_end, line_end, early_last;
   logic                  seg_close, seg_last, beat_acc, wr_hs;
   logic [DB_IDX_W-1:0]   cur_db;
   logic [ROB_IDX_W-1:0]  cur_rob;

   always_comb begin
      first_beat = (beat_cnt_q == '0) && (seg_cnt_q == '0);
      seg_end    = (beat_cnt_q == BEAT_IDX_W'(LFRX_SEG_BEATS - 1));
      line_end   = seg_end && (seg_cnt_q == REQ_NUM_W'(DS_N - 1));
`ifdef LFRX_ERR_CHK_EN
      early_last = ds_rxdat_last && !line_end;
`else
      early_last = 1'b0;
`endif
      seg_close  = seg_end || early_last;
      seg_last   = line_end || early_last;

      // Ready depends only on buffer state, never on lfdb_wr_rdy.
      ds_rxdat_rdy = !buf_full[fill_ptr_q];
      beat_acc     = ds_rxdat_vld && ds_rxdat_rdy;
      drain_seg    = buf_seg[drain_ptr_q];
      lfdb_wr_vld  = buf_full[drain_ptr_q];
      wr_hs        = lfdb_wr_vld && lfdb_wr_rdy;

      // The first beat's ids must tag the segment even if that beat closes it.
      cur_db  = first_beat ? ds_rxdat_db_entry_id  : line_db_q;
      cur_rob = first_beat ? ds_rxdat_rob_entry_id : line_rob_q;

      fill_ptr_d  = fill_ptr_q;
      drain_ptr_d = drain_ptr_q;
      beat_cnt_d  = beat_cnt_q;
      seg_cnt_d   = seg_cnt_q;
      line_db_d   = line_db_q;
      line_rob_d  = line_rob_q;

      if (beat_acc) begin
         line_db_d  = cur_db;
         line_rob_d = cur_rob;
         if (seg_close) begin
            fill_ptr_d = !fill_ptr_q;
         end
         if (early_last) begin
            beat_cnt_d = '0;
            seg_cnt_d  = '0;
         end else begin
            beat_cnt_d = seg_end ? '0 : beat_cnt_q + 1'b1;
            if (seg_end) begin
               seg_cnt_d = line_end ? '0 : seg_cnt_q + 1'b1;
            end
         end
      end
      if (wr_hs) begin
         drain_ptr_d = !drain_ptr_q;
      end

      lf_done_vld_d = wr_hs && drain_seg.last;
      lf_done_rob_d = lf_done_vld_d ? drain_seg.rob_entry_id : lf_done_rob_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_ptr_q    <= 1'b0;
         drain_ptr_q   <= 1'b0;
         beat_cnt_q    <= '0;
         seg_cnt_q     <= '0;
         line_db_q     <= '0;
         line_rob_q    <= '0;
         lf_done_vld_q <= 1'b0;
         lf_done_rob_q <= '0;
      end else begin
         fill_ptr_q    <= fill_ptr_d;
         drain_ptr_q   <= drain_ptr_d;
         beat_cnt_q    <= beat_cnt_d;
         seg_cnt_q     <= seg_cnt_d;
         line_db_q     <= line_db_d;
         line_rob_q    <= line_rob_d;
         lf_done_vld_q <= lf_done_vld_d;
         lf_done_rob_q <= lf_done_rob_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_buf
      lfrx_seg_buf u_seg_buf (
         .clk              (clk),
         .rst_n            (rst_n),
         .beat_en          (beat_acc && (fill_ptr_q == 1'(b))),
         .beat_idx         (beat_cnt_q),
         .beat_data        (ds_rxdat_data),
         .close            (seg_close),
         .tag_db_entry_id  (cur_db),
         .tag_rob_entry_id (cur_rob),
         .tag_req_num      (seg_cnt_q),
         .tag_last         (seg_last),
         .drain_ack        (wr_hs && (drain_ptr_q == 1'(b))),
         .full             (buf_full[b]),
         .seg              (buf_seg[b])
      );
   end

`ifdef LFRX_ERR_CHK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (beat_acc && (early_last || (line_end && !ds_rxdat_last))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_early_last = err_q;
`else
   // Without the checker the last flag carries no meaning.
   logic unused_last;
   assign unused_last = ds_rxdat_last;
`endif

   assign lfdb_wr_data         = drain_seg.data;
   assign lfdb_wr_db_entry_id  = drain_seg.db_entry_id;
   assign lfdb_wr_req_num      = drain_seg.req_num;
   assign lfdb_wr_last         = drain_seg.last;
   assign lf_done_vld          = lf_done_vld_q;
   assign lf_done_rob_entry_id = lf_done_rob_q;

endmodule

// File: tb/tb_ds_linefill_rx.sv
// ---------------------------------------------------------------------------
// tb_ds_linefill_rx
// Self-checking bench for ds_linefill_rx: directed line table, back-to-back,
// mid-line reset, optional early-last case and randomized lines, all checked
// against a line/segment reference model sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ds_linefill_rx;
   import ds_linefill_rx_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  ds_rxdat_vld = 1'b0;
   logic                  ds_rxdat_rdy;
   logic [BUS_WIDTH-1:0]  ds_rxdat_data = '0;
   logic                  ds_rxdat_last = 1'b0;
   logic [DB_IDX_W-1:0]   ds_rxdat_db_entry_id = '0;
   logic [ROB_IDX_W-1:0]  ds_rxdat_rob_entry_id = '0;
   logic                  lfdb_wr_vld;
   logic                  lfdb_wr_rdy = 1'b1;
   logic [DATA_WIDTH-1:0] lfdb_wr_data;
   logic [DB_IDX_W-1:0]   lfdb_wr_db_entry_id;
   logic [REQ_NUM_W-1:0]  lfdb_wr_req_num;
   logic                  lfdb_wr_last;
   logic                  lf_done_vld;
   logic [ROB_IDX_W-1:0]  lf_done_rob_entry_id;
`ifdef LFRX_ERR_CHK_EN
   logic                  err_early_last;
`endif

   ds_linefill_rx dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .ds_rxdat_vld          (ds_rxdat_vld),
      .ds_rxdat_rdy          (ds_rxdat_rdy),
      .ds_rxdat_data         (ds_rxdat_data),
      .ds_rxdat_last         (ds_rxdat_last),
      .ds_rxdat_db_entry_id  (ds_rxdat_db_entry_id),
      .ds_rxdat_rob_entry_id (ds_rxdat_rob_entry_id),
      .lfdb_wr_vld           (lfdb_wr_vld),
      .lfdb_wr_rdy           (lfdb_wr_rdy),
      .lfdb_wr_data          (lfdb_wr_data),
      .lfdb_wr_db_entry_id   (lfdb_wr_db_entry_id),
      .lfdb_wr_req_num       (lfdb_wr_req_num),
      .lfdb_wr_last          (lfdb_wr_last),
`ifdef LFRX_ERR_CHK_EN
      .err_early_last        (err_early_last),
`endif
      .lf_done_vld           (lf_done_vld),
      .lf_done_rob_entry_id  (lf_done_rob_entry_id)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit rand_rdy = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a line is a flat list of beats; every group of
   // SEG_BEATS beats (or an early close) forms one expected LFDB write.
   // ------------------------------------------------------------------
   typedef struct {
      logic [DATA_WIDTH-1:0] data;
      int                    db;
      int                    rob;
      int                    req;
      bit                    last;
   } exp_wr_t;

   exp_wr_t               exp_q[$];
   int                    m_n = 0;
   logic [DATA_WIDTH-1:0] m_data = '0;
   int                    m_db = 0;
   int                    m_rob = 0;
   bit                    m_err = 1'b0;
   bit                    done_due = 1'b0;
   int                    done_rob = 0;

   int                    obs_req[$];
   bit                    obs_last[$];
   int                    obs_db[$];
   logic [DATA_WIDTH-1:0] obs_data[$];
   int                    obs_done[$];

   task automatic model_beat(input logic [BUS_WIDTH-1:0] d, input int db, input int rob, input bit last);
      int w;
      bit early;
      if (m_n == 0) begin
         m_db  = db;
         m_rob = rob;
      end
      w = m_n % LFRX_SEG_BEATS;
      if (w == 0) m_data = '0;
      m_data[w*BUS_WIDTH +: BUS_WIDTH] = d;
      m_n++;
      early = 1'b0;
`ifdef LFRX_ERR_CHK_EN
      early = last && (m_n != LFRX_LINE_BEATS);
      if (early || (!last && m_n == LFRX_LINE_BEATS)) m_err = 1'b1;
`endif
      if (early || (m_n % LFRX_SEG_BEATS) == 0) begin
         exp_q.push_back('{m_data, m_db, m_rob, (m_n - 1) / LFRX_SEG_BEATS,
                           early || (m_n == LFRX_LINE_BEATS)});
         if (early || m_n == LFRX_LINE_BEATS) m_n = 0;
      end
   endtask

   // Falling-edge monitor: compare outputs with the model, then fold in the
   // handshakes that the coming rising edge will perform.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         exp_q.delete();
         m_n      = 0;
         m_err    = 1'b0;
         done_due = 1'b0;
      end else begin
         check("rx_rdy", ds_rxdat_rdy, exp_q.size() < 2);
         check("wr_vld", lfdb_wr_vld, exp_q.size() > 0);
         if (lfdb_wr_vld && exp_q.size() > 0) begin
            check("wr_db", lfdb_wr_db_entry_id, exp_q[0].db);
            check("wr_req_num", lfdb_wr_req_num, exp_q[0].req);
            check("wr_last", lfdb_wr_last, exp_q[0].last);
            for (int j = 0; j < LFRX_SEG_BEATS; j++)
               check($sformatf("wr_data_w%0d", j), lfdb_wr_data[j*BUS_WIDTH +: BUS_WIDTH],
                     exp_q[0].data[j*BUS_WIDTH +: BUS_WIDTH]);
         end
         check("done_vld", lf_done_vld, done_due);
         if (done_due) check("done_rob", lf_done_rob_entry_id, done_rob);
`ifdef LFRX_ERR_CHK_EN
         check("err_early_last", err_early_last, m_err);
`endif
         done_due = 1'b0;
         if (lf_done_vld) obs_done.push_back(int'(lf_done_rob_entry_id));
         if (lfdb_wr_vld && lfdb_wr_rdy) begin
            obs_req.push_back(int'(lfdb_wr_req_num));
            obs_last.push_back(lfdb_wr_last);
            obs_db.push_back(int'(lfdb_wr_db_entry_id));
            obs_data.push_back(lfdb_wr_data);
            if (exp_q.size() > 0) begin
               done_due = exp_q[0].last;
               done_rob = exp_q[0].rob;
               void'(exp_q.pop_front());
            end
         end
         if (ds_rxdat_vld && ds_rxdat_rdy)
            model_beat(ds_rxdat_data, int'(ds_rxdat_db_entry_id), int'(ds_rxdat_rob_entry_id), ds_rxdat_last);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (rand_rdy) lfdb_wr_rdy = ($urandom_range(0, 3) != 0);
   endtask

   task automatic clear_obs();
      obs_req.delete();
      obs_last.delete();
      obs_db.delete();
      obs_data.delete();
      obs_done.delete();
   endtask

   task automatic send_beat(input logic [BUS_WIDTH-1:0] d, input logic [DB_IDX_W-1:0] db,
                            input logic [ROB_IDX_W-1:0] rob, input logic last);
      bit acc = 1'b0;
      ds_rxdat_vld          = 1'b1;
      ds_rxdat_data         = d;
      ds_rxdat_db_entry_id  = db;
      ds_rxdat_rob_entry_id = rob;
      ds_rxdat_last         = last;
      for (int t = 0; t < 300 && !acc; t++) begin
         acc = ds_rxdat_rdy;
         tick();
      end
      check("beat_accepted", acc, 1'b1);
   endtask

   // Beats first..last_i of a line; data is base+i; only beat 0 carries the
   // real ids, later beats carry random ids the DUT must ignore.
   task automatic send_line_range(input logic [DB_IDX_W-1:0] db, input logic [ROB_IDX_W-1:0] rob,
                                  input logic [BUS_WIDTH-1:0] base, input int first, input int last_i,
                                  input int early_at);
      for (int i = first; i <= last_i; i++) begin
         send_beat(base + BUS_WIDTH'(i),
                   (i == 0) ? db  : DB_IDX_W'($urandom_range(0, 31)),
                   (i == 0) ? rob : ROB_IDX_W'($urandom_range(0, 63)),
                   (i == LFRX_LINE_BEATS - 1) || (i == early_at));
         if (i == early_at) break;
      end
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      ds_rxdat_vld  = 1'b0;
      ds_rxdat_last = 1'b0;
      for (int t = 0; t < 400 && !idle; t++) begin
         idle = (exp_q.size() == 0) && !lfdb_wr_vld;
         if (!idle) tick();
      end
      check("drain_idle", idle, 1'b1);
      repeat (3) tick();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rx_rdy"}, ds_rxdat_rdy, 1'b1);
      check({tag, "_wr_vld"}, lfdb_wr_vld, 1'b0);
      check({tag, "_wr_data_lo"}, lfdb_wr_data[127:0], '0);
      check({tag, "_wr_data_hi"}, lfdb_wr_data[DATA_WIDTH-1 -: 128], '0);
      check({tag, "_wr_db"}, lfdb_wr_db_entry_id, '0);
      check({tag, "_wr_req_num"}, lfdb_wr_req_num, '0);
      check({tag, "_wr_last"}, lfdb_wr_last, 1'b0);
      check({tag, "_done_vld"}, lf_done_vld, 1'b0);
      check({tag, "_done_rob"}, lf_done_rob_entry_id, '0);
`ifdef LFRX_ERR_CHK_EN
      check({tag, "_err"}, err_early_last, 1'b0);
`endif
   endtask

   // ------------------------------------------------------------------
   // Directed line table
   // ------------------------------------------------------------------
   typedef struct {
      logic [DB_IDX_W-1:0]  db;
      logic [ROB_IDX_W-1:0] rob;
      int                   base;
      bit                   stall;
      int                   exp_stall_acc;
      int                   exp_writes;
      int                   exp_done_rob;
   } vec_t;

   vec_t vecs[3];

   initial begin
      int acc;
      int c0;
      bit a;

      vecs[0] = '{db: 5'd3,  rob: 6'd5,  base: 0,      stall: 1'b0, exp_stall_acc: 0,  exp_writes: 4, exp_done_rob: 5};
      vecs[1] = '{db: 5'd1,  rob: 6'd2,  base: 100,    stall: 1'b1, exp_stall_acc: 16, exp_writes: 4, exp_done_rob: 2};
      vecs[2] = '{db: 5'd31, rob: 6'd63, base: 'h1000, stall: 1'b0, exp_stall_acc: 0,  exp_writes: 4, exp_done_rob: 63};

      repeat (3) tick();
      check_reset("por");
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 3; v++) begin
         acc = 0;
         clear_obs();
         if (vecs[v].stall) begin
            lfdb_wr_rdy = 1'b0;
            for (int c = 0; c < 40; c++) begin
               ds_rxdat_vld          = 1'b1;
               ds_rxdat_data         = BUS_WIDTH'(vecs[v].base + acc);
               ds_rxdat_db_entry_id  = (acc == 0) ? vecs[v].db  : DB_IDX_W'($urandom_range(0, 31));
               ds_rxdat_rob_entry_id = (acc == 0) ? vecs[v].rob : ROB_IDX_W'($urandom_range(0, 63));
               ds_rxdat_last         = (acc == LFRX_LINE_BEATS - 1);
               a = ds_rxdat_rdy;
               tick();
               if (a) acc++;
            end
            ds_rxdat_vld = 1'b0;
            check("stall_accepted", acc, vecs[v].exp_stall_acc);
            check("stall_rx_rdy", ds_rxdat_rdy, 1'b0);
            check("stall_no_write", obs_req.size(), 0);
            lfdb_wr_rdy = 1'b1;
         end
         send_line_range(vecs[v].db, vecs[v].rob, BUS_WIDTH'(vecs[v].base), acc, LFRX_LINE_BEATS - 1, -1);
         wait_idle();
         check("tbl_wr_count", obs_req.size(), vecs[v].exp_writes);
         for (int k = 0; k < obs_req.size(); k++) begin
            check("tbl_req_num", obs_req[k], k);
            check("tbl_last", obs_last[k], k == DS_N - 1);
            check("tbl_db", obs_db[k], vecs[v].db);
            for (int j = 0; j < LFRX_SEG_BEATS; j++)
               check("tbl_word", obs_data[k][j*BUS_WIDTH +: BUS_WIDTH],
                     BUS_WIDTH'(vecs[v].base + LFRX_SEG_BEATS*k + j));
         end
         check("tbl_done_count", obs_done.size(), 1);
         if (obs_done.size() > 0) check("tbl_done_rob", obs_done[0], vecs[v].exp_done_rob);
      end

      // Back-to-back lines: 64 beats in 64 cycles, ids switch at the line boundary.
      clear_obs();
      c0 = cyc;
      send_line_range(5'd3, 6'd5, 128'h0, 0, LFRX_LINE_BEATS - 1, -1);
      send_line_range(5'd7, 6'd9, 128'h40, 0, LFRX_LINE_BEATS - 1, -1);
      check("b2b_cycles", cyc - c0, 2 * LFRX_LINE_BEATS);
      wait_idle();
      check("b2b_wr_count", obs_req.size(), 2 * DS_N);
      for (int k = 0; k < obs_db.size(); k++) begin
         check("b2b_db", obs_db[k], (k < DS_N) ? 3 : 7);
         check("b2b_req_num", obs_req[k], k % DS_N);
      end
      check("b2b_done_count", obs_done.size(), 2);
      if (obs_done.size() == 2) begin
         check("b2b_done_rob0", obs_done[0], 5);
         check("b2b_done_rob1", obs_done[1], 9);
      end

`ifdef LFRX_ERR_CHK_EN
      // Early last on beat 10 closes segment 1 with words 3..7 zero.
      clear_obs();
      send_line_range(5'd4, 6'd6, 128'h200, 0, LFRX_LINE_BEATS - 1, 10);
      wait_idle();
      check("early_err", err_early_last, 1'b1);
      check("early_wr_count", obs_req.size(), 2);
      if (obs_req.size() == 2) begin
         check("early_req_num", obs_req[1], 1);
         check("early_last", obs_last[1], 1'b1);
         for (int j = 0; j < LFRX_SEG_BEATS; j++)
            check("early_word", obs_data[1][j*BUS_WIDTH +: BUS_WIDTH],
                  (j < 3) ? BUS_WIDTH'('h208 + j) : BUS_WIDTH'(0));
      end
      check("early_done_count", obs_done.size(), 1);
      if (obs_done.size() > 0) check("early_done_rob", obs_done[0], 6);
      clear_obs();
      send_line_range(5'd2, 6'd8, 128'h300, 0, LFRX_LINE_BEATS - 1, -1);
      wait_idle();
      check("after_early_wr_count", obs_req.size(), DS_N);
      if (obs_req.size() > 0) check("after_early_req0", obs_req[0], 0);
      check("early_err_sticky", err_early_last, 1'b1);
`endif

      // Reset after beat 12: outputs return to reset values immediately.
      send_line_range(5'd11, 6'd12, 128'h500, 0, 12, -1);
      rst_n = 1'b0;
      #1;
      check_reset("mid");
      ds_rxdat_vld = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      clear_obs();
      send_line_range(5'd13, 6'd14, 128'h600, 0, LFRX_LINE_BEATS - 1, -1);
      wait_idle();
      check("post_rst_wr_count", obs_req.size(), DS_N);
      for (int k = 0; k < obs_req.size(); k++) begin
         check("post_rst_req_num", obs_req[k], k);
         check("post_rst_db", obs_db[k], 13);
      end
      check("post_rst_done_count", obs_done.size(), 1);
      if (obs_done.size() > 0) check("post_rst_done_rob", obs_done[0], 14);

      // Randomized lines with random write backpressure and idle gaps.
      rand_rdy = 1'b1;
      for (int l = 0; l < 8; l++) begin
         int ea;
         ea = -1;
`ifdef LFRX_ERR_CHK_EN
         if ($urandom_range(0, 3) == 0) ea = int'($urandom_range(0, 30));
`endif
         send_line_range(DB_IDX_W'($urandom_range(0, 31)), ROB_IDX_W'($urandom_range(0, 63)),
                         {$urandom, $urandom, $urandom, $urandom}, 0, LFRX_LINE_BEATS - 1, ea);
         if ($urandom_range(0, 1) == 1) begin
            ds_rxdat_vld = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
         end
      end
      rand_rdy    = 1'b0;
      lfdb_wr_rdy = 1'b1;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
